// File: rtl/bus_datapath.sv
// Datapath slave of the multi-cycle controller: PC, IPR, IR, TR1/TR2, AR, register file,
// ALU and neg flag, linked by an address/selector bus (bus0) and a data bus (bus1).
module bus_datapath #(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_wr_en,
    input  logic              pc_src,
    input  logic              ir_wr_en,
    input  logic              ipr_wr_en,
    input  logic              rf_wr_en,
    input  logic              tr1_wr_en,
    input  logic              tr2_wr_en,
    input  logic              alu_en,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        db_0_s,
    input  logic [3:0]        db_1_s,
    input  logic              dm_wr_en,
    output logic [DATA_W-1:0] instruction,
    output logic              neg,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata
);
    localparam int RF_AW = $clog2(RF_DEPTH);

    localparam logic [3:0] B0_PC     = 4'b0000;
    localparam logic [3:0] B0_RS1    = 4'b0010;
    localparam logic [3:0] B0_RS2    = 4'b0011;
    localparam logic [3:0] B0_ALU    = 4'b0101;
    localparam logic [3:0] B0_PC_UPD = 4'b0110;
    localparam logic [3:0] B0_RD     = 4'b0111;
    localparam logic [3:0] B0_TR1    = 4'b1011;

    localparam logic [3:0] B1_PC     = 4'b0000;
    localparam logic [3:0] B1_IPR    = 4'b0001;
    localparam logic [3:0] B1_RF_A   = 4'b0010;
    localparam logic [3:0] B1_RF_B   = 4'b0011;
    localparam logic [3:0] B1_OFFSET = 4'b0100;
    localparam logic [3:0] B1_ALU    = 4'b0101;
    localparam logic [3:0] B1_TR2    = 4'b1010;
    localparam logic [3:0] B1_TR1    = 4'b1011;
    localparam logic [3:0] B1_DMEM   = 4'b1110;

    localparam logic [1:0] OPC_LD = 2'b10;

    logic [DATA_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] ipr_q, ipr_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] tr1_q, tr1_d;
    logic [DATA_W-1:0] tr2_q, tr2_d;
    logic [DATA_W-1:0] ar_q,  ar_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rf_d [RF_DEPTH];

    logic [1:0]               opcode;
    logic [3:0]               rd_f, rs1_f, rs2_f, offset_f;
    logic signed [DATA_W-1:0] offset_sext;
    logic [DATA_W-1:0]        rf_rdata;
    logic [DATA_W-1:0]        alu_y;
    logic [DATA_W-1:0]        bus0, bus1;
    logic                     bus0_listed;

    function automatic logic [DATA_W-1:0] alu_f(input logic [1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (op)
            2'b00:   alu_f = a + b;
            2'b01:   alu_f = a - b;
            2'b10:   alu_f = a | b;
            default: alu_f = a & b;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] zext4(input logic [3:0] f);
        zext4 = {{(DATA_W-4){1'b0}}, f};
    endfunction

    // ld swaps the roles of the two low nibbles: base register in [3:0], offset in [7:4]
    always_comb begin
        opcode      = ir_q[15:14];
        rd_f        = ir_q[11:8];
        rs2_f       = ir_q[3:0];
        rs1_f       = (opcode == OPC_LD) ? ir_q[3:0] : ir_q[7:4];
        offset_f    = (opcode == OPC_LD) ? ir_q[7:4] : ir_q[11:8];
        offset_sext = {{(DATA_W-4){offset_f[3]}}, offset_f};
    end

    assign rf_rdata = rf_q[ar_q[RF_AW-1:0]];
    assign alu_y    = alu_f(alu_op, tr1_q, tr2_q);

    always_comb begin
        bus0        = '0;
        bus0_listed = 1'b1;
        case (db_0_s)
            B0_PC, B0_PC_UPD: bus0 = pc_q;
            B0_RS1:           bus0 = zext4(rs1_f);
            B0_RS2:           bus0 = zext4(rs2_f);
            B0_ALU:           bus0 = alu_y;
            B0_RD:            bus0 = zext4(rd_f);
            B0_TR1:           bus0 = tr1_q;
            default:          bus0_listed = 1'b0;
        endcase
    end

    always_comb begin
        bus1 = '0;
        case (db_1_s)
            B1_PC:            bus1 = pc_q;
            B1_IPR:           bus1 = ipr_q;
            B1_RF_A, B1_RF_B: bus1 = rf_rdata;
            B1_OFFSET:        bus1 = offset_sext;
            B1_ALU:           bus1 = alu_y;
            B1_TR2:           bus1 = tr2_q;
            B1_TR1:           bus1 = tr1_q;
            B1_DMEM:          bus1 = dm_rdata;
            default:          bus1 = '0;
        endcase
    end

    // Every enable acts independently on pre-edge values; the RF target is the old AR.
    always_comb begin
        pc_d  = pc_q;
        ipr_d = ipr_q;
        ir_d  = ir_q;
        tr1_d = tr1_q;
        tr2_d = tr2_q;
        ar_d  = ar_q;
        neg_d = neg_q;
        rf_d  = rf_q;
        if (pc_wr_en)    pc_d  = pc_src ? alu_y : pc_q + DATA_W'(1);
        if (ipr_wr_en)   ipr_d = imem_rdata;
        if (ir_wr_en)    ir_d  = bus1;
        if (tr1_wr_en)   tr1_d = bus1;
        if (tr2_wr_en)   tr2_d = bus1;
        if (bus0_listed) ar_d  = bus0;
        if (alu_en)      neg_d = alu_y[DATA_W-1];
        if (rf_wr_en)    rf_d[ar_q[RF_AW-1:0]] = bus1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            ipr_q <= '0;
            ir_q  <= '0;
            tr1_q <= '0;
            tr2_q <= '0;
            ar_q  <= '0;
            neg_q <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ipr_q <= ipr_d;
            ir_q  <= ir_d;
            tr1_q <= tr1_d;
            tr2_q <= tr2_d;
            ar_q  <= ar_d;
            neg_q <= neg_d;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign instruction = ir_q;
    assign neg         = neg_q;
    assign imem_addr   = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = bus1;
    assign dm_we       = dm_wr_en;

endmodule

// File: tb/tb_bus_datapath.sv
// Bench for bus_datapath: directed scenarios plus a randomized run against a behavioural model.
module tb_bus_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wr_en, pc_src, ir_wr_en, ipr_wr_en, rf_wr_en;
    logic        tr1_wr_en, tr2_wr_en, alu_en, dm_wr_en;
    logic [1:0]  alu_op;
    logic [3:0]  db_0_s, db_1_s;
    logic [15:0] instruction, imem_addr, imem_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        neg, dm_we;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_pc, m_ipr, m_ir, m_tr1, m_tr2, m_ar;
    logic        m_neg;
    logic [15:0] m_rf [16];

    bus_datapath #(.DATA_W(16), .RF_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .pc_wr_en(pc_wr_en), .pc_src(pc_src), .ir_wr_en(ir_wr_en),
        .ipr_wr_en(ipr_wr_en), .rf_wr_en(rf_wr_en), .tr1_wr_en(tr1_wr_en), .tr2_wr_en(tr2_wr_en),
        .alu_en(alu_en), .alu_op(alu_op), .db_0_s(db_0_s), .db_1_s(db_1_s), .dm_wr_en(dm_wr_en),
        .instruction(instruction), .neg(neg), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] m_alu();
        case (alu_op)
            2'd0:    return m_tr1 + m_tr2;
            2'd1:    return m_tr1 - m_tr2;
            2'd2:    return m_tr1 | m_tr2;
            default: return m_tr1 & m_tr2;
        endcase
    endfunction

    function automatic logic [15:0] m_bus0();
        logic is_ld;
        is_ld = (m_ir[15:14] == 2'b10);
        case (db_0_s)
            4'd0, 4'd6: return m_pc;
            4'd2:       return is_ld ? {12'h0, m_ir[3:0]} : {12'h0, m_ir[7:4]};
            4'd3:       return {12'h0, m_ir[3:0]};
            4'd5:       return m_alu();
            4'd7:       return {12'h0, m_ir[11:8]};
            4'd11:      return m_tr1;
            default:    return 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] m_bus1();
        int off;
        off = (m_ir[15:14] == 2'b10) ? int'(m_ir[7:4]) : int'(m_ir[11:8]);
        if (off >= 8) off = off - 16;
        case (db_1_s)
            4'd0:       return m_pc;
            4'd1:       return m_ipr;
            4'd2, 4'd3: return m_rf[m_ar[3:0]];
            4'd4:       return 16'(off);
            4'd5:       return m_alu();
            4'd10:      return m_tr2;
            4'd11:      return m_tr1;
            4'd14:      return dm_rdata;
            default:    return 16'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_pc = 0; m_ipr = 0; m_ir = 0; m_tr1 = 0; m_tr2 = 0; m_ar = 0; m_neg = 0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    endtask

    task automatic step();
        logic [15:0] b0, b1, y, n_pc, n_ipr, n_ir, n_tr1, n_tr2, n_ar;
        logic        n_neg, do_rf, ar_ok;
        logic [3:0]  rf_idx;
        b0 = m_bus0(); b1 = m_bus1(); y = m_alu();
        ar_ok  = db_0_s inside {4'd0, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd11};
        n_pc   = pc_wr_en ? (pc_src ? y : m_pc + 16'd1) : m_pc;
        n_ipr  = ipr_wr_en ? imem_rdata : m_ipr;
        n_ir   = ir_wr_en ? b1 : m_ir;
        n_tr1  = tr1_wr_en ? b1 : m_tr1;
        n_tr2  = tr2_wr_en ? b1 : m_tr2;
        n_ar   = ar_ok ? b0 : m_ar;
        n_neg  = alu_en ? y[15] : m_neg;
        do_rf  = rf_wr_en;
        rf_idx = m_ar[3:0];
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ipr = n_ipr; m_ir = n_ir; m_tr1 = n_tr1; m_tr2 = n_tr2;
        m_ar = n_ar; m_neg = n_neg;
        if (do_rf) m_rf[rf_idx] = b1;
    endtask

    task automatic idle();
        pc_wr_en = 0; pc_src = 0; ir_wr_en = 0; ipr_wr_en = 0; rf_wr_en = 0;
        tr1_wr_en = 0; tr2_wr_en = 0; alu_en = 0; dm_wr_en = 0; alu_op = 2'd0;
        db_0_s = 4'b1111; db_1_s = 4'b1111; dm_rdata = 16'h0; imem_rdata = 16'h0;
    endtask

    task automatic load_tr1(input logic [15:0] v);
        idle(); dm_rdata = v; db_1_s = 4'b1110; tr1_wr_en = 1; step(); idle();
    endtask

    task automatic load_tr2(input logic [15:0] v);
        idle(); dm_rdata = v; db_1_s = 4'b1110; tr2_wr_en = 1; step(); idle();
    endtask

    task automatic load_ir(input logic [15:0] v);
        idle(); dm_rdata = v; db_1_s = 4'b1110; ir_wr_en = 1; step(); idle();
    endtask

    task automatic set_ar(input logic [15:0] v);
        load_tr1(v); db_0_s = 4'b1011; step(); idle();
    endtask

    task automatic rf_write(input logic [15:0] a, input logic [15:0] v);
        set_ar(a); dm_rdata = v; db_1_s = 4'b1110; rf_wr_en = 1; step(); idle();
    endtask

    task automatic set_pc(input logic [15:0] v);
        load_tr1(v); load_tr2(16'h0); alu_op = 2'd0; pc_wr_en = 1; pc_src = 1; step(); idle();
    endtask

    task automatic do_reset();
        idle(); rst = 0; #1; m_reset();
        @(posedge clk); #1;
        rst = 1; #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        @(posedge clk); #1;
        dm_wr_en = 1; rst = 0; #1; m_reset();
        checks++; if (instruction !== 16'h0) begin failures++; $display("FAIL reset_instruction got=%h exp=0000", instruction); end
        checks++; if (neg !== 1'b0) begin failures++; $display("FAIL reset_neg got=%b exp=0", neg); end
        checks++; if (imem_addr !== 16'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0000", imem_addr); end
        checks++; if (dm_addr !== 16'h0) begin failures++; $display("FAIL reset_dm_addr got=%h exp=0000", dm_addr); end
        checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL reset_dm_we_follow got=%b exp=1", dm_we); end
        @(posedge clk); #1;
        idle(); rst = 1; #1;
    endtask

    task automatic test_fetch();
        idle(); imem_rdata = 16'h1234; ipr_wr_en = 1; step();
        idle(); db_1_s = 4'b0001; #1;
        checks++; if (dm_wdata !== 16'h1234) begin failures++; $display("FAIL fetch_ipr got=%h exp=1234", dm_wdata); end
        ir_wr_en = 1; step(); idle(); #1;
        checks++; if (instruction !== 16'h1234) begin failures++; $display("FAIL fetch_ir got=%h exp=1234", instruction); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL fetch_pc got=%h exp=0000", imem_addr); end
    endtask

    task automatic test_add();
        rf_write(16'd5, 16'd7);
        rf_write(16'd6, 16'd3);
        load_ir(16'h0356);
        db_0_s = 4'b0010; step(); idle(); #1;
        checks++; if (dm_addr !== 16'd5) begin failures++; $display("FAIL add_ar_rs1 got=%h exp=0005", dm_addr); end
        db_1_s = 4'b0010; tr1_wr_en = 1; db_0_s = 4'b0011; step(); idle();
        db_1_s = 4'b0010; tr2_wr_en = 1; db_0_s = 4'b0111; step(); idle();
        alu_op = 2'b00; alu_en = 1; db_1_s = 4'b0101; tr2_wr_en = 1; step(); idle();
        rf_wr_en = 1; db_1_s = 4'b1010; step(); idle();
        db_1_s = 4'b0010; #1;
        checks++; if (dm_addr !== 16'd3) begin failures++; $display("FAIL add_ar_rd got=%h exp=0003", dm_addr); end
        checks++; if (dm_wdata !== 16'd10) begin failures++; $display("FAIL add_rf_rd got=%h exp=000a", dm_wdata); end
        checks++; if (neg !== 1'b0) begin failures++; $display("FAIL add_neg got=%b exp=0", neg); end
    endtask

    task automatic test_sub_neg();
        load_tr1(16'd3); load_tr2(16'd5);
        alu_op = 2'b01; alu_en = 1; db_1_s = 4'b0101; #1;
        checks++; if (dm_wdata !== 16'hFFFE) begin failures++; $display("FAIL sub_alu_y got=%h exp=fffe", dm_wdata); end
        step(); idle(); #1;
        checks++; if (neg !== 1'b1) begin failures++; $display("FAIL sub_neg_set got=%b exp=1", neg); end
        load_tr1(16'd5); #1;
        checks++; if (neg !== 1'b1) begin failures++; $display("FAIL sub_neg_hold got=%b exp=1", neg); end
        alu_op = 2'b01; alu_en = 1; step(); idle(); #1;
        checks++; if (neg !== 1'b0) begin failures++; $display("FAIL sub_neg_clear got=%b exp=0", neg); end
    endtask

    task automatic test_branch();
        set_pc(16'h0010); #1;
        checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL br_pc_init got=%h exp=0010", imem_addr); end
        load_ir(16'h4E00);
        db_1_s = 4'b0000; tr1_wr_en = 1; step(); idle();
        db_1_s = 4'b0100; #1;
        checks++; if (dm_wdata !== 16'hFFFE) begin failures++; $display("FAIL br_sext got=%h exp=fffe", dm_wdata); end
        tr2_wr_en = 1; step(); idle();
        alu_op = 2'b00; pc_wr_en = 1; pc_src = 1; step(); idle(); #1;
        checks++; if (imem_addr !== 16'h000E) begin failures++; $display("FAIL br_pc_target got=%h exp=000e", imem_addr); end
        load_ir(16'h80E0); db_1_s = 4'b0100; #1;
        checks++; if (dm_wdata !== 16'hFFFE) begin failures++; $display("FAIL ld_offset_sext got=%h exp=fffe", dm_wdata); end
    endtask

    task automatic test_pc_wrap_illegal();
        set_pc(16'hFFFF); #1;
        checks++; if (imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_pc_init got=%h exp=ffff", imem_addr); end
        pc_wr_en = 1; pc_src = 0; step(); idle(); #1;
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", imem_addr); end
        load_tr1(16'hA5A5);
        db_1_s = 4'b1111; tr1_wr_en = 1; step(); idle();
        db_1_s = 4'b1011; #1;
        checks++; if (dm_wdata !== 16'h0000) begin failures++; $display("FAIL illegal_bus1 got=%h exp=0000", dm_wdata); end
        load_tr2(16'h1357);
        db_1_s = 4'b1010; tr2_wr_en = 1; step(); idle();
        db_1_s = 4'b1010; #1;
        checks++; if (dm_wdata !== 16'h1357) begin failures++; $display("FAIL self_reload got=%h exp=1357", dm_wdata); end
    endtask

    task automatic test_ld_sd_reset();
        set_ar(16'h0004);
        dm_rdata = 16'hBEEF; db_1_s = 4'b1110; tr1_wr_en = 1; step(); idle();
        db_1_s = 4'b1011; #1;
        checks++; if (dm_wdata !== 16'hBEEF) begin failures++; $display("FAIL ld_tr1 got=%h exp=beef", dm_wdata); end
        load_tr2(16'h5A5A);
        dm_wr_en = 1; db_1_s = 4'b1010; #1;
        checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL sd_we got=%b exp=1", dm_we); end
        checks++; if (dm_wdata !== 16'h5A5A) begin failures++; $display("FAIL sd_wdata got=%h exp=5a5a", dm_wdata); end
        checks++; if (dm_addr !== 16'h0004) begin failures++; $display("FAIL sd_addr got=%h exp=0004", dm_addr); end
        #1; rst = 0; #1; m_reset();
        checks++; if (dm_wdata !== 16'h0000) begin failures++; $display("FAIL rst_sd_wdata got=%h exp=0000", dm_wdata); end
        checks++; if (dm_addr !== 16'h0000) begin failures++; $display("FAIL rst_sd_addr got=%h exp=0000", dm_addr); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_sd_pc got=%h exp=0000", imem_addr); end
        checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL rst_sd_we_follow got=%b exp=1", dm_we); end
        dm_wr_en = 0; #1;
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL rst_sd_we_drop got=%b exp=0", dm_we); end
        @(posedge clk); #1;
        idle(); rst = 1; #1;
        db_1_s = 4'b0010; #1;
        checks++; if (dm_wdata !== 16'h0000) begin failures++; $display("FAIL rst_rf_clear got=%h exp=0000", dm_wdata); end
        idle();
    endtask

    task automatic test_random();
        logic [15:0] exp_b1;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            {pc_wr_en, pc_src, ir_wr_en, ipr_wr_en, rf_wr_en,
             tr1_wr_en, tr2_wr_en, alu_en, dm_wr_en} = 9'($urandom);
            alu_op     = 2'($urandom);
            db_0_s     = 4'($urandom);
            db_1_s     = 4'($urandom);
            dm_rdata   = 16'($urandom);
            imem_rdata = 16'($urandom);
            #1;
            exp_b1 = m_bus1();
            checks++;
            if (dm_wdata !== exp_b1) begin
                failures++; $display("FAIL rnd_bus1 n=%0d sel=%h got=%h exp=%h", n, db_1_s, dm_wdata, exp_b1);
            end
            checks++;
            if ({instruction, imem_addr, dm_addr, neg, dm_we} !== {m_ir, m_pc, m_ar, m_neg, dm_wr_en}) begin
                failures++;
                $display("FAIL rnd_state n=%0d got=%h/%h/%h/%b/%b exp=%h/%h/%h/%b/%b", n, instruction, imem_addr,
                         dm_addr, neg, dm_we, m_ir, m_pc, m_ar, m_neg, dm_wr_en);
            end
            step();
        end
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        m_reset();
        test_reset();
        test_fetch();
        test_add();
        test_sub_neg();
        test_branch();
        test_pc_wrap_illegal();
        test_ld_sd_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
